fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter and issues requests to the instruction memory with a req/ack handshake.
- Latches the returned word into the instruction register, which drives im_out to the decoder.
- Computes the next PC from the decoder's branch-taken (sIn0_Mux) and jump (sIn_Pc) selects when the decoder accepts the instruction.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory over a
// req/ack handshake, and holds each fetched word in the IR until the decoder accepts it.
module fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 BR_OFF_W = 6,
  parameter int                 MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] im_out,
  output logic               ir_valid,
  input  logic               ir_accept,
  input  logic               take_branch,
  input  logic               take_jump,
  input  logic               stall,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               imem_err
);

  localparam int JMP_W  = 10;
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [WAIT_W-1:0]   wait_q;

  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   br_off;
  logic [ADDR_W-1:0]   next_pc;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign br_off = {{(ADDR_W-BR_OFF_W){ir_q[BR_OFF_W-1]}}, ir_q[BR_OFF_W-1:0]};

  // Jump keeps the upper PC bits of the sequential successor and replaces the low page.
  always_comb begin
    next_pc = pc_inc;
    if (take_jump)
      next_pc = {pc_inc[ADDR_W-1:JMP_W], ir_q[JMP_W-1:0]};
    else if (take_branch)
      next_pc = pc_inc + br_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      wait_q  <= '0;
    end else if (!stall) begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            state_q <= HOLD;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ERROR;
          end else begin
            wait_q  <= wait_q + WAIT_W'(1);
          end
        end
        HOLD: begin
          if (ir_accept) begin
            pc_q    <= next_pc;
            state_q <= FETCH;
            wait_q  <= '0;
          end
        end
        ERROR: begin
          state_q <= ERROR;
        end
        default: begin
          state_q <= ERROR;
        end
      endcase
    end
  end

  // The request is masked during reset so an abandoned fetch never reaches memory.
  assign imem_req  = (state_q == FETCH) && !rst;
  assign imem_addr = pc_q;
  assign im_out    = ir_q;
  assign ir_valid  = (state_q == HOLD);
  assign pc_out    = pc_q;
  assign imem_err  = (state_q == ERROR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, next-PC selection, PC wrap,
// stall freezing and the fetch-timeout error path.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_accept;
  logic        take_branch;
  logic        take_jump;
  logic        stall;

  logic        imem_req,  imem_req2;
  logic [15:0] imem_addr, imem_addr2;
  logic [15:0] im_out,    im_out2;
  logic        ir_valid,  ir_valid2;
  logic [15:0] pc_out,    pc_out2;
  logic        imem_err,  imem_err2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .im_out(im_out), .ir_valid(ir_valid), .ir_accept(ir_accept),
    .take_branch(take_branch), .take_jump(take_jump), .stall(stall),
    .pc_out(pc_out), .imem_err(imem_err)
  );

  // Second instance starts at the top of the address space to exercise the wrap.
  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .im_out(im_out2), .ir_valid(ir_valid2), .ir_accept(ir_accept),
    .take_branch(take_branch), .take_jump(take_jump), .stall(stall),
    .pc_out(pc_out2), .imem_err(imem_err2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
      else begin
        n_err++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic r, input logic ack, input logic [15:0] data,
                               input logic acc, input logic br, input logic jp, input logic st);
    rst         = r;
    imem_ack    = ack;
    imem_rdata  = data;
    ir_accept   = acc;
    take_branch = br;
    take_jump   = jp;
    stall       = st;
    @(posedge clk);
    #1;
  endtask

  task automatic fetchOne(input logic [15:0] data);
    applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic acceptOne(input logic br, input logic jp);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, br, jp, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Reset with a stray ack present in every reset cycle.
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_req",      imem_req, 1'b0);
    checkOutput("rst_valid",    ir_valid, 1'b0);
    checkOutput("rst_im_out",   im_out,   16'h0000);
    checkOutput("rst_err",      imem_err, 1'b0);
    checkOutput("rst_pc",       pc_out,   16'h0000);
    checkOutput("rst_pc_wrap",  pc_out2,  16'hFFFF);

    // First FETCH cycle without ack, then ack on the second.
    rst = 1'b0; imem_ack = 1'b0; #1;
    checkOutput("f1_req",  imem_req,  1'b1);
    checkOutput("f1_addr", imem_addr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("f2_valid", ir_valid, 1'b0);
    fetchOne(16'h1234);
    checkOutput("ack_valid",  ir_valid, 1'b1);
    checkOutput("ack_im_out", im_out,   16'h1234);
    checkOutput("ack_req",    imem_req, 1'b0);
    checkOutput("ack_wrap",   im_out2,  16'h1234);
    acceptOne(1'b0, 1'b0);
    checkOutput("seq_addr",   imem_addr,  16'h0001);
    checkOutput("seq_req",    imem_req,   1'b1);
    checkOutput("seq_valid",  ir_valid,   1'b0);
    checkOutput("wrap_addr",  imem_addr2, 16'h0000);

    // Jump to 0x010, then branch -2 and +5 from there.
    fetchOne(16'h0010);
    acceptOne(1'b0, 1'b1);
    checkOutput("jmp_010", imem_addr, 16'h0010);
    fetchOne(16'h003E);
    checkOutput("pc_at_010", pc_out, 16'h0010);
    acceptOne(1'b1, 1'b0);
    checkOutput("br_neg2", imem_addr, 16'h000F);
    fetchOne(16'h0010);
    acceptOne(1'b0, 1'b1);
    fetchOne(16'h0005);
    acceptOne(1'b1, 1'b0);
    checkOutput("br_pos5", imem_addr, 16'h0016);

    // Walk to 0x410 and check jump beats branch with upper bits preserved.
    fetchOne(16'h03FF);
    acceptOne(1'b0, 1'b1);
    checkOutput("jmp_3ff", imem_addr, 16'h03FF);
    fetchOne(16'h0000);
    acceptOne(1'b0, 1'b0);
    checkOutput("seq_400", imem_addr, 16'h0400);
    fetchOne(16'h000F);
    acceptOne(1'b1, 1'b0);
    checkOutput("br_410", imem_addr, 16'h0410);
    fetchOne(16'h0123);
    acceptOne(1'b1, 1'b1);
    checkOutput("jmp_wins", imem_addr, 16'h0523);

    // Stall in HOLD with accept held for three cycles.
    fetchOne(16'hABCD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("stall_pc",    pc_out,   16'h0523);
      checkOutput("stall_ir",    im_out,   16'hABCD);
      checkOutput("stall_valid", ir_valid, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("unstall_br", imem_addr, 16'h0531);

    // Stalled ack in FETCH is ignored; accept/jump are ignored without a valid IR.
    applyStimulus(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall_ack_valid", ir_valid, 1'b0);
    checkOutput("stall_ack_req",   imem_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_accept_pc", pc_out, 16'h0531);

    // Timeout: the request has now waited one cycle; 15 more reach ERROR.
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_pre_err", imem_err, 1'b0);
    checkOutput("to_pre_req", imem_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_err", imem_err, 1'b1);
    checkOutput("to_req", imem_req, 1'b0);
    fetchOne(16'h7777);
    checkOutput("late_ack_valid", ir_valid, 1'b0);
    checkOutput("late_ack_err",   imem_err, 1'b1);

    // Reset clears the error and restarts at RESET_PC.
    applyStimulus(1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ack_valid", ir_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_err",  imem_err,  1'b0);
    checkOutput("post_rst_addr", imem_addr, 16'h0000);
    checkOutput("post_rst_req",  imem_req,  1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
